// File: rtl/ffxkclk_pkg.sv
// Shared constants and helpers for the ffxkclk delay-line datapath.
// FFXKCLK_OBUF_BYPASS_EN selects which minimum depth the check enforces.
`ifndef FFXKCLK_PKG_SV
`define FFXKCLK_PKG_SV

`ifdef SYNTHESIS
`define FFXKCLK_DEPTH_CHECK(d, k)
`else
// Elaboration-time guard: a buffer shallower than the round trip cannot hold full rate.
`define FFXKCLK_DEPTH_CHECK(d, k) if ((d) < ffxkclk_pkg::FFXKCLK_MIN_DEPTH(k)) begin : g_depth_check $error("ffxkclk: depth %0d below minimum %0d", (d), ffxkclk_pkg::FFXKCLK_MIN_DEPTH(k)); end
`endif

package ffxkclk_pkg;

    function automatic int ffxkclk_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int FFXKCLK_MIN_DEPTH(input int k);
`ifdef FFXKCLK_OBUF_BYPASS_EN
        return k + 1;
`else
        return k + 2;
`endif
    endfunction

endpackage

`endif

// File: rtl/ffxkclk_obuf_mem.sv
// D x W storage for ffxkclk_obuf: synchronous write, asynchronous read.
module ffxkclk_obuf_mem
    import ffxkclk_pkg::*;
#(
    parameter int W  = 10,
    parameter int D  = 8,
    parameter int AW = ffxkclk_clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ffxkclk_obuf.sv
// Credit-controlled output buffer behind the non-stallable ffxkclkx delay line.
// Optional same-cycle bypass of an empty FIFO: FFXKCLK_OBUF_BYPASS_EN.
module ffxkclk_obuf
    import ffxkclk_pkg::*;
#(
    parameter int W  = 10,
    parameter int K  = 3,
    parameter int D  = 8,
    parameter int AW = ffxkclk_clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          ireq_ok,
    input  logic          ireq,
    input  logic          ivld,
    input  logic [W-1:0]  idat,
    output logic          ovld,
    input  logic          ordy,
    output logic [W-1:0]  odat,
    output logic [AW:0]   ocnt,
    output logic          oerr
);

    `FFXKCLK_DEPTH_CHECK(D, K)

    localparam logic [AW:0] DEPTH = (AW+1)'(D);

    logic [AW:0]   cred;
    logic [AW:0]   cnt;
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [W-1:0]  head;
    logic [W-1:0]  last;
    logic          fifo_vld;
    logic          full;
    logic          byp;
    logic          pop;
    logic          fifo_pop;
    logic          wr;
    logic          take;
    logic          viol;
    logic          drop;

    assign fifo_vld = (cnt != '0);
    assign full     = (cnt == DEPTH);

    // Output handshake: a word transfers on any cycle with ovld & ordy; ovld is
    // never a function of ordy, and once raised stays up with stable odat until taken.
`ifdef FFXKCLK_OBUF_BYPASS_EN
    assign byp  = ~fifo_vld & ivld;
    assign ovld = fifo_vld | byp;
    assign odat = fifo_vld ? head : (byp ? idat : last);
`else
    assign byp  = 1'b0;
    assign ovld = fifo_vld;
    assign odat = fifo_vld ? head : last;
`endif

    assign pop      = ovld & ordy;
    assign fifo_pop = pop & fifo_vld;
    // A bypassed word that is taken immediately never touches the array.
    assign wr       = ivld & (~full | pop) & ~(byp & ordy);
    assign drop     = ivld & full & ~pop;
    assign take     = ireq & ireq_ok;
    assign viol     = ireq & ~ireq_ok;

    assign ireq_ok  = (cred != '0);
    assign ocnt     = cnt;

    ffxkclk_obuf_mem #(
        .W  (W),
        .D  (D),
        .AW (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr (wp),
        .wdata (idat),
        .raddr (rp),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cred <= DEPTH;
            cnt  <= '0;
            wp   <= '0;
            rp   <= '0;
            last <= '0;
            oerr <= 1'b0;
        end else begin
            if (take && !pop) begin
                cred <= cred - (AW+1)'(1);
            end else if (pop && !take && cred != DEPTH) begin
                cred <= cred + (AW+1)'(1);
            end

            if (wr && !fifo_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (fifo_pop && !wr) begin
                cnt <= cnt - (AW+1)'(1);
            end

            if (wr)       wp <= wp + AW'(1);
            if (fifo_pop) rp <= rp + AW'(1);
            if (pop)      last <= odat;
            if (viol || drop) oerr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ffxkclk_obuf.sv
// Self-checking bench for ffxkclk_obuf: delay-line emulation, queue model, random traffic.
// Bypass expectations follow FFXKCLK_OBUF_BYPASS_EN.
module tb_ffxkclk_obuf;

    localparam int W  = 10;
    localparam int K  = 3;
    localparam int D  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ireq = 1'b0;
    logic          ivld;
    logic [W-1:0]  idat;
    logic          ordy = 1'b0;
    logic          ireq_ok;
    logic          ovld;
    logic [W-1:0]  odat;
    logic [AW:0]   ocnt;
    logic          oerr;

    always #5 clk = ~clk;

    ffxkclk_obuf #(.W(W), .K(K), .D(D), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .ireq_ok (ireq_ok),
        .ireq    (ireq),
        .ivld    (ivld),
        .idat    (idat),
        .ovld    (ovld),
        .ordy    (ordy),
        .odat    (odat),
        .ocnt    (ocnt),
        .oerr    (oerr)
    );

    // Upstream delay line: ivld/idat are ireq and its word K cycles later.
    logic         dl_v [K];
    logic [W-1:0] dl_d [K];
    logic         inj = 1'b0;
    logic [W-1:0] inj_dat = '0;
    logic [W-1:0] launch_seq = '0;

    assign ivld = dl_v[K-1] | inj;
    assign idat = inj ? inj_dat : dl_d[K-1];

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int ok_hi = 0;
    int ok_low = 0;
    int max_cnt = 0;
    logic [W-1:0] last_pop = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: expected queue of stored words plus credit and error state.
    logic [W-1:0] exp_q[$];
    int           m_cred = D;
    bit           m_err = 1'b0;
    logic [W-1:0] m_last = '0;
    bit           model_ok = 1'b0;

    function automatic void predict(output bit v, output logic [W-1:0] d, output bit byp);
        byp = 1'b0;
`ifdef FFXKCLK_OBUF_BYPASS_EN
        byp = (exp_q.size() == 0) && (ivld === 1'b1);
`endif
        v = (exp_q.size() != 0) || byp;
        d = (exp_q.size() != 0) ? exp_q[0] : (byp ? idat : m_last);
    endfunction

    always @(posedge clk) begin
        bit           v;
        bit           byp;
        bit           p;
        logic [W-1:0] d;
        int           c;
        if (rst) begin
            exp_q.delete();
            m_cred   = D;
            m_err    = 1'b0;
            m_last   = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            predict(v, d, byp);
            p = v && ordy;
            c = m_cred;
            if (ireq) begin
                if (m_cred == 0) m_err = 1'b1;
                else c = c - 1;
            end
            if (p) c = c + 1;
            if (c > D) c = D;
            m_cred = c;
            if (p) begin
                m_last = d;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (ivld) begin
                if (byp && ordy) begin
                    // consumed straight through
                end else if (exp_q.size() < D) begin
                    exp_q.push_back(idat);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit           v;
        bit           byp;
        logic [W-1:0] d;
        if (model_ok) begin
            predict(v, d, byp);
            check("ireq_ok", ireq_ok, m_cred != 0);
            check("ovld", ovld, v);
            check("ocnt", ocnt, exp_q.size());
            check("oerr", oerr, m_err);
            check("odat", odat, d);
            if (ovld && ordy) begin
                pop_cnt++;
                last_pop = odat;
            end
            if (int'(ocnt) > max_cnt) max_cnt = int'(ocnt);
        end
    end

    // One cycle of stimulus: r = 0 idle, 1 launch, 2 launch randomly when permitted.
    task automatic cyc(input int r, input logic o, input logic in, input logic rs);
        @(posedge clk);
        #1;
        for (int i = K-1; i > 0; i--) begin
            dl_v[i] = dl_v[i-1];
            dl_d[i] = dl_d[i-1];
        end
        dl_v[0] = ireq;
        dl_d[0] = launch_seq;
        if (ireq) launch_seq = launch_seq + 1'b1;
        if (rst) begin
            for (int i = 0; i < K; i++) dl_v[i] = 1'b0;
        end
        ireq = (r == 1) || (r == 2 && ireq_ok && $urandom_range(0, 3) != 0);
        if (r != 0 && ireq_ok) ok_hi++;
        if (r == 1 && !ireq_ok) ok_low++;
        ordy    = o;
        inj     = in;
        inj_dat = W'($urandom);
        rst     = rs;
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        logic [W-1:0] base;
        int           n0;
        for (int i = 0; i < K; i++) begin
            dl_v[i] = 1'b0;
            dl_d[i] = '0;
        end

        // Reset and idle
        do_reset();
        check("rst_ireq_ok", ireq_ok, 1);
        check("rst_ovld", ovld, 0);
        check("rst_ocnt", ocnt, 0);
        check("rst_oerr", oerr, 0);
        check("rst_odat", odat, 0);

        // Eight launches with the consumer stalled exhaust all credits
        repeat (D) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("fill_ireq_ok", ireq_ok, 0);
        repeat (K) cyc(0, 0, 0, 0);
        check("fill_ocnt", ocnt, 8);
        repeat (D + 2) cyc(0, 1, 0, 0);
        check("drain_ocnt", ocnt, 0);
        check("drain_ireq_ok", ireq_ok, 1);

        // Full-rate streaming
        pop_cnt = 0;
        ok_low  = 0;
        base    = launch_seq;
        repeat (100) cyc(1, 1, 0, 0);
        repeat (K + 3) cyc(0, 1, 0, 0);
        check("stream_pops", pop_cnt, 100);
        check("stream_last", last_pop, base + W'(99));
        check("stream_ok_low", ok_low, 0);
        check("stream_oerr", oerr, 0);

        // Random backpressure with a well-behaved upstream
        pop_cnt = 0;
        max_cnt = 0;
        n0      = int'(launch_seq);
        repeat (300) cyc(2, $urandom_range(0, 2) == 0, 0, 0);
        repeat (40) cyc(0, 1, 0, 0);
        check("bp_all_out", pop_cnt, (int'(launch_seq) - n0 + 1024) % 1024);
        check("bp_max_ocnt", max_cnt <= D, 1);
        check("bp_oerr", oerr, 0);

        // Launch without a permit
        do_reset();
        repeat (D) cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("viol_oerr", oerr, 1);
        check("viol_ireq_ok", ireq_ok, 0);
        repeat (K + 1) cyc(0, 0, 0, 0);
        check("viol_ocnt", ocnt, 8);

        // Word arriving at a full, stalled FIFO is dropped
        do_reset();
        repeat (D) cyc(1, 0, 0, 0);
        repeat (K + 1) cyc(0, 0, 0, 0);
        check("ovf_pre_oerr", oerr, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        check("ovf_oerr", oerr, 1);
        check("ovf_ocnt", ocnt, 8);

        // Full FIFO with simultaneous arrival and pop
        do_reset();
        base = launch_seq;
        repeat (D) cyc(1, 0, 0, 0);
        repeat (K + 1) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 0);
        cyc(0, 0, 0, 0);
        check("fullpop_ocnt", ocnt, 8);
        check("fullpop_oerr", oerr, 0);
        check("fullpop_popped", last_pop, base);
        check("fullpop_head", odat, base + W'(1));

        // Reset mid-operation
        do_reset();
        repeat (5) cyc(1, 0, 0, 0);
        repeat (K + 1) cyc(0, 0, 0, 0);
        check("mid_ocnt5", ocnt, 5);
        do_reset();
        check("mid_ocnt", ocnt, 0);
        check("mid_ovld", ovld, 0);
        check("mid_ireq_ok", ireq_ok, 1);
        ok_hi = 0;
        repeat (10) cyc(1, 0, 0, 0);
        check("mid_credits", ok_hi, 8);
        do_reset();

`ifdef FFXKCLK_OBUF_BYPASS_EN
        // Same-cycle pass-through of an empty FIFO
        pop_cnt = 0;
        base = launch_seq;
        cyc(1, 1, 0, 0);
        repeat (K) cyc(0, 1, 0, 0);
        check("byp_ovld", ovld, 1);
        check("byp_odat", odat, base);
        cyc(0, 1, 0, 0);
        check("byp_ocnt", ocnt, 0);
        check("byp_pops", pop_cnt, 1);
        check("byp_ireq_ok", ireq_ok, 1);
`endif

        repeat (2) cyc(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
